// File: rtl/uart_prog_loader.sv
// Boot loader: receives 8N1 UART bytes, packs them MSB-byte first into 32-bit words and
// writes them to instruction memory until the end-of-program word arrives.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 86,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned MEM_DEPTH    = 16384,
  parameter logic [31:0] EOP_WORD     = 32'h00000FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              rx_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              frame_err_o,
  output logic              ovf_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StStart   = 3'd1;
  localparam logic [2:0] StData    = 3'd2;
  localparam logic [2:0] StStop    = 3'd3;
  localparam logic [2:0] StCleanup = 3'd4;

  logic            rx_meta_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     word_q, word_d, word_asm;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  // One extra bit so that addr == MEM_DEPTH is representable for overflow detection.
  logic [ADDR_W:0] addr_q, addr_d;
  logic            done_q, done_d;
  logic            frame_err_q, frame_err_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q && !done_q) begin
            state_d   = StStart;
            clk_cnt_d = '0;
          end
        end
        StStart: begin
          if (clk_cnt_q == HalfM1) begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            state_d   = rx_s_q ? StIdle : StData;
          end else begin
            clk_cnt_d = clk_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (clk_cnt_q == FullM1) begin
            clk_cnt_d = '0;
            shift_d   = {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_d = StStop;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            clk_cnt_d = clk_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (clk_cnt_q == FullM1) begin
            clk_cnt_d = '0;
            state_d   = StCleanup;
            if (rx_s_q) byte_valid_d = 1'b1;
            else        frame_err_d  = 1'b1;
          end else begin
            clk_cnt_d = clk_cnt_q + CntW'(1);
          end
        end
        StCleanup: begin
          // After a framing error the line may still be low; wait for idle.
          if (rx_s_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    word_asm = word_q;
    unique case (byte_cnt_q)
      2'd0: word_asm[31:24] = shift_q;
      2'd1: word_asm[23:16] = shift_q;
      2'd2: word_asm[15:8]  = shift_q;
      2'd3: word_asm[7:0]   = shift_q;
      default: word_asm = word_q;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    if (we_q) addr_d = addr_q + (ADDR_W + 1)'(1);
    if (!en_i) begin
      byte_cnt_d = '0;
    end else if (byte_valid_q) begin
      word_d     = word_asm;
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) begin
        if (word_asm == EOP_WORD) begin
          done_d = 1'b1;
        end else if (addr_q < (ADDR_W + 1)'(MEM_DEPTH)) begin
          we_d    = 1'b1;
          wdata_d = word_asm;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      addr_q       <= '0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q[ADDR_W-1:0];
  assign wdata_o     = wdata_q;
  assign busy_o      = (state_q != StIdle) || (byte_cnt_q != 2'd0);
  assign done_o      = done_q;
  assign frame_err_o = frame_err_q;
  assign ovf_o       = ovf_q;

endmodule
